// File: rtl/kf8253_pkg.sv
// kf8253_pkg: shared types and decode helpers for the 8253 timer channel.
package kf8253_pkg;

   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE2 = 2'd1,
      MODE3 = 2'd2,
      MODE4 = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      RW_LATCH = 2'd0,
      RW_LSB   = 2'd1,
      RW_MSB   = 2'd2,
      RW_BOTH  = 2'd3
   } rw_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      COUNT = 2'd2
   } count_state_t;

   // Modes 1/5 fold onto 0/4 and the don't-care encodings 6/7 onto 2/3.
   function automatic mode_t decode_mode(input logic [2:0] field);
      mode_t m;
      case (field)
         3'd0, 3'd1: m = MODE0;
         3'd2, 3'd6: m = MODE2;
         3'd3, 3'd7: m = MODE3;
         3'd4, 3'd5: m = MODE4;
         default:    m = MODE0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/kf8253_edge_sync.sv
// kf8253_edge_sync: multi-stage synchroniser for an asynchronous input with
// level, rising-edge and falling-edge outputs in the system clock domain.
module kf8253_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // Shift the input through the synchroniser and keep one delayed copy for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign level = sync_r[SYNC_STAGES-1];
   assign rise  = level & ~prev_r;
   assign fall  = ~level & prev_r;

endmodule

// File: rtl/kf8253_counter_channel.sv
// kf8253_counter_channel: one 8253 counting channel (modes 0, 2, 3, 4; binary
// counting). Holds mode, count register, counting element and output latch.
module kf8253_counter_channel
   import kf8253_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] internal_data_bus,
   input  logic       write_control,
   input  logic       write_counter,
   input  logic       read_counter,
   input  logic       counter_clock,
   input  logic       gate,
   output logic       counter_out,
   output logic [7:0] read_data
);

   mode_t        mode_r, ctrl_mode_s;
   rw_t          rw_r, ctrl_rw_s;
   count_state_t state_r, state_nxt_s;
   logic         bcd_r, wr_toggle_r, rd_toggle_r, latch_pending_r, read_prev_r;
   logic         out_r, reload_r, out_nxt_s, reload_nxt_s;
   logic [7:0]   lsb_r;
   logic [15:0]  count_reg_r, element_r, latch_r, element_nxt_s;
   logic [15:0]  dec1_s, dec2_s, high2_s, low2_s, read_src_s;
   logic         count_edge_s, cclk_level_s, cclk_rise_s;
   logic         gate_level_s, gate_rise_s, gate_fall_s;
   logic         ctrl_load_s, write_complete_s, halt_s, read_fall_s, periodic_s;
   logic         unused_s;

   kf8253_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cclk_sync (
      .clock(clock), .reset_n(reset_n), .async_in(counter_clock),
      .level(cclk_level_s), .rise(cclk_rise_s), .fall(count_edge_s)
   );

   kf8253_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_gate_sync (
      .clock(clock), .reset_n(reset_n), .async_in(gate),
      .level(gate_level_s), .rise(gate_rise_s), .fall(gate_fall_s)
   );

   assign ctrl_rw_s   = rw_t'(internal_data_bus[5:4]);
   assign ctrl_mode_s = decode_mode(internal_data_bus[3:1]);
   assign ctrl_load_s = write_control && (ctrl_rw_s != RW_LATCH);
   assign write_complete_s = write_counter && ((rw_r == RW_LSB) || (rw_r == RW_MSB) ||
                                               ((rw_r == RW_BOTH) && wr_toggle_r));
   // Mode 0 stops counting between the two bytes of a 16-bit rewrite.
   assign halt_s      = (mode_r == MODE0) && (rw_r == RW_BOTH) && wr_toggle_r;
   assign read_fall_s = read_prev_r && !read_counter;
   assign periodic_s  = (mode_r == MODE2) || (mode_r == MODE3);
   assign dec1_s      = element_r - 16'd1;
   assign dec2_s      = element_r - 16'd2;
   // Mode 3 half periods are held doubled so the element steps by two: high gets the odd extra count.
   assign low2_s      = {count_reg_r[15:1], 1'b0};
   assign high2_s     = low2_s + {14'd0, count_reg_r[0], 1'b0};
   assign unused_s    = ^{internal_data_bus[7:6], bcd_r, cclk_level_s, cclk_rise_s, gate_fall_s};

   // Channel state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: control words park the channel; complete counts arm a load.
   always_comb begin
      state_nxt_s = state_r;
      if (ctrl_load_s) begin
         state_nxt_s = IDLE;
      end else if (write_complete_s) begin
         if ((state_r == COUNT) && periodic_s) begin
            state_nxt_s = COUNT;
         end else begin
            state_nxt_s = LOAD;
         end
      end else if ((state_r == LOAD) && count_edge_s && !halt_s) begin
         state_nxt_s = COUNT;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Element, output and gate-reload updates for the current cycle.
   always_comb begin
      element_nxt_s = element_r;
      out_nxt_s     = out_r;
      reload_nxt_s  = reload_r | ((state_r == COUNT) && periodic_s && gate_rise_s);
      if (ctrl_load_s) begin
         out_nxt_s    = (ctrl_mode_s != MODE0);
         reload_nxt_s = 1'b0;
      end else if (write_counter && (mode_r == MODE0)) begin
         out_nxt_s = 1'b0;
      end else if (count_edge_s && !halt_s && (state_r == LOAD)) begin
         element_nxt_s = (mode_r == MODE3) ? high2_s : count_reg_r;
         out_nxt_s     = (mode_r != MODE0);
         reload_nxt_s  = 1'b0;
      end else if (count_edge_s && !halt_s && (state_r == COUNT) && gate_level_s) begin
         case (mode_r)
            MODE0: begin
               element_nxt_s = dec1_s;
               out_nxt_s     = out_r | (dec1_s == 16'd0);
            end
            MODE2: begin
               if (reload_r || gate_rise_s || (element_r == 16'd1)) begin
                  element_nxt_s = count_reg_r;
                  out_nxt_s     = 1'b1;
                  reload_nxt_s  = 1'b0;
               end else begin
                  element_nxt_s = dec1_s;
                  out_nxt_s     = (dec1_s != 16'd1);
               end
            end
            MODE3: begin
               if (reload_r || gate_rise_s) begin
                  element_nxt_s = high2_s;
                  out_nxt_s     = 1'b1;
                  reload_nxt_s  = 1'b0;
               end else if (element_r == 16'd2) begin
                  element_nxt_s = out_r ? low2_s : high2_s;
                  out_nxt_s     = !out_r;
               end else begin
                  element_nxt_s = dec2_s;
               end
            end
            MODE4: begin
               element_nxt_s = dec1_s;
               out_nxt_s     = (dec1_s != 16'd0);
            end
            default: begin
               element_nxt_s = element_r;
            end
         endcase
      end else if ((state_r == COUNT) && periodic_s && !gate_level_s) begin
         out_nxt_s = 1'b1;
      end else begin
         element_nxt_s = element_r;
      end
   end

   // Counting element, output pin and pending gate reload.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         element_r <= 16'd0;
         out_r     <= 1'b0;
         reload_r  <= 1'b0;
      end else begin
         element_r <= element_nxt_s;
         out_r     <= out_nxt_s;
         reload_r  <= reload_nxt_s;
      end
   end

   // Control word, count byte assembly, latch and read toggle bookkeeping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_r          <= MODE0;
         rw_r            <= RW_BOTH;
         bcd_r           <= 1'b0;
         count_reg_r     <= 16'd0;
         lsb_r           <= 8'd0;
         wr_toggle_r     <= 1'b0;
         rd_toggle_r     <= 1'b0;
         latch_r         <= 16'd0;
         latch_pending_r <= 1'b0;
      end else if (write_control) begin
         if (ctrl_rw_s == RW_LATCH) begin
            if (!latch_pending_r) begin
               latch_r         <= element_r;
               latch_pending_r <= 1'b1;
            end
         end else begin
            mode_r          <= ctrl_mode_s;
            rw_r            <= ctrl_rw_s;
            bcd_r           <= internal_data_bus[0];
            latch_pending_r <= 1'b0;
            wr_toggle_r     <= 1'b0;
            rd_toggle_r     <= 1'b0;
         end
      end else begin
         if (write_counter) begin
            case (rw_r)
               RW_LSB:  count_reg_r <= {8'h00, internal_data_bus};
               RW_MSB:  count_reg_r <= {internal_data_bus, 8'h00};
               RW_BOTH: begin
                  if (!wr_toggle_r) begin
                     lsb_r <= internal_data_bus;
                  end else begin
                     count_reg_r <= {internal_data_bus, lsb_r};
                  end
                  wr_toggle_r <= !wr_toggle_r;
               end
               default: count_reg_r <= count_reg_r;
            endcase
         end
         if (read_fall_s) begin
            if (rw_r == RW_BOTH) begin
               rd_toggle_r <= !rd_toggle_r;
               if (rd_toggle_r) begin
                  latch_pending_r <= 1'b0;
               end
            end else begin
               latch_pending_r <= 1'b0;
            end
         end
      end
   end

   // Delayed read strobe for detecting the end of each read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_prev_r <= 1'b0;
      end else begin
         read_prev_r <= read_counter;
      end
   end

   assign read_src_s  = latch_pending_r ? latch_r : element_r;
   assign counter_out = out_r;

   // Select the read-back byte from the latch or live element.
   always_comb begin
      read_data = read_src_s[7:0];
      case (rw_r)
         RW_LSB:  read_data = read_src_s[7:0];
         RW_MSB:  read_data = read_src_s[15:8];
         RW_BOTH: read_data = rd_toggle_r ? read_src_s[15:8] : read_src_s[7:0];
         default: read_data = read_src_s[7:0];
      endcase
   end

endmodule

// File: tb/tb_kf8253_counter_channel.sv
// tb_kf8253_counter_channel: randomized self-checking bench; expected values come
// from per-mode arithmetic on the number of count edges since the last load.
module tb_kf8253_counter_channel;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] internal_data_bus = 8'h00;
   logic       write_control = 1'b0;
   logic       write_counter = 1'b0;
   logic       read_counter = 1'b0;
   logic       counter_clock = 1'b0;
   logic       gate = 1'b1;
   logic       counter_out;
   logic [7:0] read_data;

   int compared = 0;
   int mismatched = 0;

   kf8253_counter_channel #(.SYNC_STAGES(2)) dut (
      .clock(clock), .reset_n(reset_n), .internal_data_bus(internal_data_bus),
      .write_control(write_control), .write_counter(write_counter),
      .read_counter(read_counter), .counter_clock(counter_clock), .gate(gate),
      .counter_out(counter_out), .read_data(read_data)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, compared=%0d", compared);
      $fatal(1, "timeout");
   end

   // Reference rules: k = count edges since the load edge (k=0 is the load edge).
   function automatic logic m0_out(input int k, input int n);
      return (k >= n);
   endfunction
   function automatic logic m2_out(input int k, input int n);
      return ((k % n) != (n - 1));
   endfunction
   function automatic int m2_elem(input int k, input int n);
      return n - (k % n);
   endfunction
   function automatic logic m3_out(input int k, input int n);
      return ((k % n) < ((n + 1) / 2));
   endfunction
   function automatic logic m4_out(input int k, input int n);
      return (k != n);
   endfunction

   task automatic write_ctrl(input logic [7:0] b);
      @(negedge clock); internal_data_bus = b; write_control = 1'b1;
      @(negedge clock); write_control = 1'b0;
   endtask

   task automatic write_cnt(input logic [7:0] b);
      @(negedge clock); internal_data_bus = b; write_counter = 1'b1;
      @(negedge clock); write_counter = 1'b0;
   endtask

   task automatic count_edge();
      @(negedge clock); counter_clock = 1'b1;
      repeat (4) @(negedge clock);
      counter_clock = 1'b0;
      repeat (5) @(negedge clock);
   endtask

   task automatic read_byte(output logic [7:0] b);
      @(negedge clock); read_counter = 1'b1;
      @(negedge clock); b = read_data; read_counter = 1'b0;
      @(negedge clock);
   endtask

   task automatic read_word(output logic [15:0] w);
      logic [7:0] lo, hi;
      read_byte(lo);
      read_byte(hi);
      w = {hi, lo};
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      compared++;
      if (counter_out !== 1'b0) begin mismatched++; $display("FAIL reset_out: got %0b expected 0", counter_out); end
      compared++;
      if (read_data !== 8'h00) begin mismatched++; $display("FAIL reset_read: got %02h expected 00", read_data); end
      reset_n = 1'b1;
      repeat (6) @(negedge clock);
   endtask

   task automatic test_mode0();
      int n;
      logic [15:0] w;
      for (int it = 0; it < 2; it++) begin
         n = (it == 0) ? 5 : int'($urandom_range(3, 10));
         write_ctrl(8'h30);
         compared++;
         if (counter_out !== 1'b0) begin mismatched++; $display("FAIL m0_ctrl_out: got %0b expected 0", counter_out); end
         write_cnt(n[7:0]);
         write_cnt(8'h00);
         for (int k = 0; k <= n + 1; k++) begin
            count_edge();
            compared++;
            if (counter_out !== m0_out(k, n)) begin
               mismatched++; $display("FAIL m0_out n=%0d k=%0d: got %0b expected %0b", n, k, counter_out, m0_out(k, n));
            end
         end
         read_word(w);
         compared++;
         if (w !== 16'hFFFF) begin mismatched++; $display("FAIL m0_wrap: got %04h expected FFFF", w); end
         // First byte of a new pair: output drops, counting halts.
         write_cnt(8'h03);
         compared++;
         if (counter_out !== 1'b0) begin mismatched++; $display("FAIL m0_halt_out: got %0b expected 0", counter_out); end
         count_edge();
         count_edge();
         read_word(w);
         compared++;
         if (w !== 16'hFFFF) begin mismatched++; $display("FAIL m0_halt_elem: got %04h expected FFFF", w); end
         write_cnt(8'h00);
         for (int k = 0; k <= 4; k++) begin
            count_edge();
            compared++;
            if (counter_out !== m0_out(k, 3)) begin
               mismatched++; $display("FAIL m0_reload_out k=%0d: got %0b expected %0b", k, counter_out, m0_out(k, 3));
            end
         end
      end
   endtask

   task automatic test_mode2();
      int n, m;
      logic [15:0] w;
      n = int'($urandom_range(3, 8));
      write_ctrl(8'h34);
      compared++;
      if (counter_out !== 1'b1) begin mismatched++; $display("FAIL m2_ctrl_out: got %0b expected 1", counter_out); end
      write_cnt(n[7:0]);
      write_cnt(8'h00);
      for (int k = 0; k < 2 * n; k++) begin
         count_edge();
         compared++;
         if (counter_out !== m2_out(k, n)) begin
            mismatched++; $display("FAIL m2_out n=%0d k=%0d: got %0b expected %0b", n, k, counter_out, m2_out(k, n));
         end
      end
      read_word(w);
      compared++;
      if (w !== 16'(m2_elem(2 * n - 1, n))) begin mismatched++; $display("FAIL m2_elem: got %04h expected %04h", w, 16'(m2_elem(2 * n - 1, n))); end
      // Gate low: output forced high, count frozen.
      gate = 1'b0;
      repeat (6) @(negedge clock);
      compared++;
      if (counter_out !== 1'b1) begin mismatched++; $display("FAIL m2_gate_force: got %0b expected 1", counter_out); end
      for (int g = 0; g < 3; g++) begin
         count_edge();
         compared++;
         if (counter_out !== 1'b1) begin mismatched++; $display("FAIL m2_gate_hold g=%0d: got %0b expected 1", g, counter_out); end
      end
      read_word(w);
      compared++;
      if (w !== 16'd1) begin mismatched++; $display("FAIL m2_gate_frozen: got %04h expected 0001", w); end
      // Gate rising edge reloads on the following count edge.
      gate = 1'b1;
      for (int k = 0; k <= n; k++) begin
         count_edge();
         compared++;
         if (counter_out !== m2_out(k, n)) begin
            mismatched++; $display("FAIL m2_gate_reload k=%0d: got %0b expected %0b", k, counter_out, m2_out(k, n));
         end
      end
      // New count during counting is used from the next reload on.
      m = n + 2;
      write_cnt(m[7:0]);
      write_cnt(8'h00);
      for (int k = 1; k < n; k++) begin
         count_edge();
         compared++;
         if (counter_out !== m2_out(k, n)) begin
            mismatched++; $display("FAIL m2_old_count k=%0d: got %0b expected %0b", k, counter_out, m2_out(k, n));
         end
      end
      for (int k = 0; k <= m; k++) begin
         count_edge();
         compared++;
         if (counter_out !== m2_out(k, m)) begin
            mismatched++; $display("FAIL m2_new_count k=%0d: got %0b expected %0b", k, counter_out, m2_out(k, m));
         end
      end
      read_word(w);
      compared++;
      if (w !== 16'(m)) begin mismatched++; $display("FAIL m2_new_elem: got %04h expected %04h", w, 16'(m)); end
   endtask

   task automatic test_mode3();
      int n;
      for (int it = 0; it < 3; it++) begin
         n = (it == 0) ? 5 : (it == 1) ? 4 : int'($urandom_range(3, 9));
         write_ctrl(8'h36);
         write_cnt(n[7:0]);
         write_cnt(8'h00);
         for (int k = 0; k < 2 * n + 1; k++) begin
            count_edge();
            compared++;
            if (counter_out !== m3_out(k, n)) begin
               mismatched++; $display("FAIL m3_out n=%0d k=%0d: got %0b expected %0b", n, k, counter_out, m3_out(k, n));
            end
         end
      end
   endtask

   task automatic test_mode4();
      int n;
      logic [15:0] w;
      n = int'($urandom_range(3, 8));
      write_ctrl(8'h38);
      write_cnt(n[7:0]);
      write_cnt(8'h00);
      for (int k = 0; k <= n + 2; k++) begin
         count_edge();
         compared++;
         if (counter_out !== m4_out(k, n)) begin
            mismatched++; $display("FAIL m4_out n=%0d k=%0d: got %0b expected %0b", n, k, counter_out, m4_out(k, n));
         end
      end
      read_word(w);
      compared++;
      if (w !== 16'hFFFE) begin mismatched++; $display("FAIL m4_wrap: got %04h expected FFFE", w); end
   endtask

   task automatic test_latch();
      logic [15:0] n, latched, live;
      logic [7:0] b;
      n = 16'($urandom_range(16'h0400, 16'hF000));
      write_ctrl(8'h30);
      write_cnt(n[7:0]);
      write_cnt(n[15:8]);
      repeat (4) count_edge();
      latched = n - 16'd3;
      write_ctrl(8'h00);
      compared++;
      if (counter_out !== 1'b0) begin mismatched++; $display("FAIL latch_out: got %0b expected 0", counter_out); end
      repeat (2) count_edge();
      live = n - 16'd5;
      write_ctrl(8'h00);
      read_byte(b);
      compared++;
      if (b !== latched[7:0]) begin mismatched++; $display("FAIL latch_lsb: got %02h expected %02h", b, latched[7:0]); end
      read_byte(b);
      compared++;
      if (b !== latched[15:8]) begin mismatched++; $display("FAIL latch_msb: got %02h expected %02h", b, latched[15:8]); end
      read_byte(b);
      compared++;
      if (b !== live[7:0]) begin mismatched++; $display("FAIL latch_live_lsb: got %02h expected %02h", b, live[7:0]); end
      read_byte(b);
      compared++;
      if (b !== live[15:8]) begin mismatched++; $display("FAIL latch_live_msb: got %02h expected %02h", b, live[15:8]); end
   endtask

   task automatic test_lsb_only();
      logic [7:0] b;
      write_ctrl(8'h10);
      write_cnt(8'h80);
      for (int k = 0; k <= 129; k++) begin
         count_edge();
         compared++;
         if (counter_out !== m0_out(k, 128)) begin
            mismatched++; $display("FAIL lsb_only_out k=%0d: got %0b expected %0b", k, counter_out, m0_out(k, 128));
         end
         if (k == 0 || k == 3) begin
            for (int r = 0; r < 2; r++) begin
               read_byte(b);
               compared++;
               if (b !== 8'(128 - k)) begin mismatched++; $display("FAIL lsb_only_read k=%0d r=%0d: got %02h expected %02h", k, r, b, 8'(128 - k)); end
            end
         end
      end
   endtask

   task automatic test_reset_midcount();
      int n;
      logic [15:0] w;
      n = int'($urandom_range(4, 9));
      write_ctrl(8'h34);
      write_cnt(n[7:0]);
      write_cnt(8'h00);
      repeat (3) count_edge();
      @(negedge clock); reset_n = 1'b0;
      #1;
      compared++;
      if (counter_out !== 1'b0) begin mismatched++; $display("FAIL rst_mid_out: got %0b expected 0", counter_out); end
      compared++;
      if (read_data !== 8'h00) begin mismatched++; $display("FAIL rst_mid_read: got %02h expected 00", read_data); end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) count_edge();
      compared++;
      if (counter_out !== 1'b0) begin mismatched++; $display("FAIL rst_idle_out: got %0b expected 0", counter_out); end
      read_word(w);
      compared++;
      if (w !== 16'h0000) begin mismatched++; $display("FAIL rst_idle_elem: got %04h expected 0000", w); end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode2();
      test_mode3();
      test_mode4();
      test_latch();
      test_lsb_only();
      test_reset_midcount();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
